checker_hm_arbiter: RTL and testbench



---
 rtl/checker_hm_arbiter_pkg.sv | 17 +
 rtl/checker_hm_arbiter_if.sv | 31 +++
 rtl/checker_hm_arbiter_rr_pick.sv | 29 ++
 rtl/checker_hm_arbiter.sv | 166 ++++++++++++++++
 tb/tb_checker_hm_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/checker_hm_arbiter_pkg.sv
// Shared types and constants for the host-memory read-port arbiter.
package checker_hm_arbiter_pkg;

  // Default number of requesters sharing the host-memory port.
  localparam int unsigned CHECKER_HMARB_NREQ = 2;

  // Width of the optional hm_end watchdog counter.
  localparam int unsigned CHECKER_HMARB_TMO_W = 16;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/checker_hm_arbiter_if.sv
// Host-memory read port bundle: start/end level handshake plus address and data.
interface checker_hm_arbiter_if;

  logic [63:0] hm_page_addr;
  logic [11:0] hm_page_offset;
  logic        hm_start;
  logic        hm_end;
  logic [63:0] hm_data;
  logic        hm_error;

  // The arbiter issues requests to host memory.
  modport master (
    output hm_page_addr,
    output hm_page_offset,
    output hm_start,
    input  hm_end,
    input  hm_data,
    input  hm_error
  );

  // Host memory (PCIe hm_top or the simulation model) answers them.
  modport slave (
    input  hm_page_addr,
    input  hm_page_offset,
    input  hm_start,
    output hm_end,
    output hm_data,
    output hm_error
  );

endinterface

// File: rtl/checker_hm_arbiter_rr_pick.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping modulo NREQ.
module checker_rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic             valid
);

  int unsigned idx;

  // Scan requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr) + i) % NREQ;
      if (!valid && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        valid                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/checker_hm_arbiter.sv
// Round-robin arbiter sharing the single host-memory read port between NREQ
// requesters; one transaction outstanding at a time.
// Optional hm_end watchdog: define CHECKER_HM_ARB_TIMEOUT_EN.
module checker_hm_arbiter
  import checker_hm_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = CHECKER_HMARB_NREQ,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NREQ-1:0]      req_start,
  input  logic [NREQ*64-1:0]   req_page_addr,
  input  logic [NREQ*12-1:0]   req_page_offset,
  output logic [NREQ-1:0]      req_end,
  output logic [NREQ-1:0]      req_error,
  output logic [63:0]          req_data,
  output logic [NREQ-1:0]      grant,
  checker_hm_arbiter_if.master hm
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2) begin : g_bad_cfg
    $error("checker_hm_arbiter: NREQ must be 2..4 and TIMEOUT at least 2");
  end

  state_t             state;
  state_t             next_state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [NREQ-1:0]    pick_grant;
  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [63:0]        sel_addr;
  logic [11:0]        sel_off;
  logic [PTR_W-1:0]   next_ptr;
  logic               tmo;

  checker_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req_start),
    .ptr   (ptr),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Turn the picker's one-hot grant into an index and select that requester's address.
  always_comb begin
    pick_idx = '0;
    sel_addr = '0;
    sel_off  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        pick_idx = PTR_W'(i);
        sel_addr = req_page_addr[64*i +: 64];
        sel_off  = req_page_offset[12*i +: 12];
      end
    end
  end

  // Pointer moves to the requester just after the one being completed.
  always_comb begin
    next_ptr = (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
  end

`ifdef CHECKER_HM_ARB_TIMEOUT_EN
  logic [CHECKER_HMARB_TMO_W-1:0] tmo_cnt;

  // Watchdog: counts WAIT cycles, held at zero in every other state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || state != WAIT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + CHECKER_HMARB_TMO_W'(1);
    end
  end

  // Timeout fires on the last allowed WAIT cycle; a real hm_end in that cycle wins.
  always_comb begin
    tmo = (state == WAIT) && !hm.hm_end &&
          (tmo_cnt == CHECKER_HMARB_TMO_W'(TIMEOUT - 1));
  end
`else
  // Without the watchdog WAIT lasts until hm_end.
  always_comb begin
    tmo = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; new requests are only considered from IDLE.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (pick_valid)          next_state = WAIT;
      WAIT:    if (hm.hm_end || tmo)    next_state = RELEASE;
      RELEASE: if (!req_start[gidx])    next_state = IDLE;
      default:                          next_state = IDLE;
    endcase
  end

  // Registered outputs and datapath: grant/latch in IDLE, complete in WAIT,
  // drop grant once the served requester has released its request.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant             <= '0;
      gidx              <= '0;
      ptr               <= '0;
      req_end           <= '0;
      req_error         <= '0;
      req_data          <= '0;
      hm.hm_start       <= 1'b0;
      hm.hm_page_addr   <= '0;
      hm.hm_page_offset <= '0;
    end else begin
      req_end   <= '0;
      req_error <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            grant             <= pick_grant;
            gidx              <= pick_idx;
            hm.hm_start       <= 1'b1;
            hm.hm_page_addr   <= sel_addr;
            hm.hm_page_offset <= sel_off;
          end
        end
        WAIT: begin
          if (hm.hm_end) begin
            req_data        <= hm.hm_data;
            req_end[gidx]   <= 1'b1;
            req_error[gidx] <= hm.hm_error;
            hm.hm_start     <= 1'b0;
            ptr             <= next_ptr;
          end else if (tmo) begin
            req_end[gidx]   <= 1'b1;
            req_error[gidx] <= 1'b1;
            hm.hm_start     <= 1'b0;
            ptr             <= next_ptr;
          end
        end
        RELEASE: begin
          if (!req_start[gidx]) begin
            grant <= '0;
          end
        end
        default: begin
          grant       <= '0;
          hm.hm_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checker_hm_arbiter.sv
// Self-checking bench for checker_hm_arbiter: vector table, hand-written
// corner sequences, and randomized traffic against a transaction-level model.
module tb_checker_hm_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned TMO  = 8;

  localparam logic [63:0] A0 = 64'h0000_0000_0000_1000;
  localparam logic [63:0] A1 = 64'h0000_0000_0000_2000;
  localparam logic [11:0] O0 = 12'h010;
  localparam logic [11:0] O1 = 12'h020;
  localparam logic [63:0] J  = 64'h0BAD_0BAD_0BAD_0BAD;
  localparam logic [63:0] D1 = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D3 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] D4 = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [63:0] D5 = 64'h0123_4567_89AB_CDEF;

  logic                sys_clk = 1'b0;
  logic                sys_rst;
  logic [NREQ-1:0]     req_start;
  logic [NREQ*64-1:0]  req_page_addr;
  logic [NREQ*12-1:0]  req_page_offset;
  logic [NREQ-1:0]     req_end;
  logic [NREQ-1:0]     req_error;
  logic [63:0]         req_data;
  logic [NREQ-1:0]     grant;

  checker_hm_arbiter_if hm_if ();

  checker_hm_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TMO)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst         (sys_rst),
    .req_start       (req_start),
    .req_page_addr   (req_page_addr),
    .req_page_offset (req_page_offset),
    .req_end         (req_end),
    .req_error       (req_error),
    .req_data        (req_data),
    .grant           (grant),
    .hm              (hm_if)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [NREQ-1:0] eg, input logic es,
                           input logic [NREQ-1:0] ee, input logic [NREQ-1:0] eer,
                           input logic [63:0] ed, input logic [63:0] ea, input logic [11:0] eo);
    check({tag, " grant"},     64'(grant),                eg);
    check({tag, " hm_start"},  64'(hm_if.hm_start),       es);
    check({tag, " req_end"},   64'(req_end),              ee);
    check({tag, " req_error"}, 64'(req_error),            eer);
    check({tag, " req_data"},  req_data,                  ed);
    check({tag, " hm_addr"},   hm_if.hm_page_addr,        ea);
    check({tag, " hm_offset"}, 64'(hm_if.hm_page_offset), eo);
  endtask

  task automatic set_fixed_addr();
    req_page_addr   = {A1, A0};
    req_page_offset = {O1, O0};
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic            rst;
    logic [NREQ-1:0] rs;
    logic            he;
    logic            herr;
    logic [63:0]     hd;
    logic [NREQ-1:0] eg;
    logic            es;
    logic [NREQ-1:0] ee;
    logic [NREQ-1:0] eer;
    logic [63:0]     ed;
    logic [63:0]     ea;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] rs, input logic he,
                              input logic herr, input logic [63:0] hd, input logic [1:0] eg,
                              input logic es, input logic [1:0] ee, input logic [1:0] eer,
                              input logic [63:0] ed, input logic [63:0] ea);
    vec_t v;
    v = '{rst, rs, he, herr, hd, eg, es, ee, eer, ed, ea};
    return v;
  endfunction

  // ---------------- transaction-level reference model ----------------
  // owner: requester holding the port (-1 if none); answered: its read has returned.
  int              owner = -1;
  bit              answered;
  int              m_ptr;
  int              waited;
  logic [NREQ-1:0] m_grant, m_end, m_err;
  logic            m_start;
  logic [63:0]     m_data, m_addr;
  logic [11:0]     m_off;

  task automatic model_step();
    m_end = '0;
    m_err = '0;
    if (sys_rst) begin
      owner = -1; answered = 0; m_ptr = 0;
      m_start = 0; m_data = '0; m_addr = '0; m_off = '0;
    end else if (owner < 0) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        int j;
        j = (m_ptr + k) % int'(NREQ);
        if (req_start[j]) begin
          owner    = j;
          answered = 0;
          waited   = 0;
          m_start  = 1;
          m_addr   = req_page_addr[64*j +: 64];
          m_off    = req_page_offset[12*j +: 12];
          break;
        end
      end
    end else if (!answered) begin
      if (hm_if.hm_end) begin
        m_data        = hm_if.hm_data;
        m_end[owner]  = 1'b1;
        m_err[owner]  = hm_if.hm_error;
        answered      = 1;
      end
`ifdef CHECKER_HM_ARB_TIMEOUT_EN
      else if (waited == int'(TMO) - 1) begin
        m_end[owner] = 1'b1;
        m_err[owner] = 1'b1;
        answered     = 1;
      end else begin
        waited++;
      end
`endif
      if (answered) begin
        m_start = 0;
        m_ptr   = (owner + 1) % int'(NREQ);
      end
    end else if (!req_start[owner]) begin
      owner = -1;
    end
    m_grant = '0;
    if (owner >= 0) m_grant[owner] = 1'b1;
  endtask

  vec_t        tbl[24];
  int unsigned hold[NREQ];
  int unsigned idle[NREQ];
  bit          done_seen[NREQ];

  initial begin
    // table filled first: one row per cycle, inputs then expected post-edge outputs
    tbl[0]  = mk(0, 2'b01, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, '0, A0);
    tbl[1]  = mk(0, 2'b01, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, '0, A0);
    tbl[2]  = mk(0, 2'b01, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, '0, A0);
    tbl[3]  = mk(0, 2'b01, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, '0, A0);
    tbl[4]  = mk(0, 2'b01, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, '0, A0);
    tbl[5]  = mk(0, 2'b01, 1, 0, D1, 2'b01, 0, 2'b01, 2'b00, D1, A0);
    tbl[6]  = mk(0, 2'b00, 0, 0, J,  2'b00, 0, 2'b00, 2'b00, D1, A0);
    tbl[7]  = mk(1, 2'b00, 1, 1, J,  2'b00, 0, 2'b00, 2'b00, '0, '0);
    tbl[8]  = mk(0, 2'b11, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, '0, A0);
    tbl[9]  = mk(0, 2'b11, 1, 0, D2, 2'b01, 0, 2'b01, 2'b00, D2, A0);
    tbl[10] = mk(0, 2'b10, 0, 0, J,  2'b00, 0, 2'b00, 2'b00, D2, A0);
    tbl[11] = mk(0, 2'b11, 0, 0, J,  2'b10, 1, 2'b00, 2'b00, D2, A1);
    tbl[12] = mk(0, 2'b11, 1, 1, D3, 2'b10, 0, 2'b10, 2'b10, D3, A1);
    tbl[13] = mk(0, 2'b01, 0, 0, J,  2'b00, 0, 2'b00, 2'b00, D3, A1);
    tbl[14] = mk(0, 2'b11, 0, 0, J,  2'b01, 1, 2'b00, 2'b00, D3, A0);
    tbl[15] = mk(0, 2'b11, 1, 0, D4, 2'b01, 0, 2'b01, 2'b00, D4, A0);
    tbl[16] = mk(0, 2'b11, 1, 1, J,  2'b01, 0, 2'b00, 2'b00, D4, A0);
    tbl[17] = mk(0, 2'b11, 1, 1, J,  2'b01, 0, 2'b00, 2'b00, D4, A0);
    tbl[18] = mk(0, 2'b11, 1, 1, J,  2'b01, 0, 2'b00, 2'b00, D4, A0);
    tbl[19] = mk(0, 2'b10, 0, 0, J,  2'b00, 0, 2'b00, 2'b00, D4, A0);
    tbl[20] = mk(0, 2'b10, 0, 0, J,  2'b10, 1, 2'b00, 2'b00, D4, A1);
    tbl[21] = mk(0, 2'b10, 1, 0, D5, 2'b10, 0, 2'b10, 2'b00, D5, A1);
    tbl[22] = mk(0, 2'b00, 0, 0, J,  2'b00, 0, 2'b00, 2'b00, D5, A1);
    tbl[23] = mk(0, 2'b00, 1, 1, D1, 2'b00, 0, 2'b00, 2'b00, D5, A1);

    // reset values
    sys_rst = 1'b1;
    req_start = '0;
    set_fixed_addr();
    hm_if.hm_end = 1'b0;
    hm_if.hm_error = 1'b0;
    hm_if.hm_data = '0;
    tick();
    tick();
    check_all("reset", '0, 0, '0, '0, '0, '0, '0);
    sys_rst = 1'b0;

    // table-driven vectors
    for (int unsigned r = 0; r < 24; r++) begin
      logic [11:0] eo;
      sys_rst        = tbl[r].rst;
      req_start      = tbl[r].rs;
      hm_if.hm_end   = tbl[r].he;
      hm_if.hm_error = tbl[r].herr;
      hm_if.hm_data  = tbl[r].hd;
      tick();
      eo = (tbl[r].ea == A0) ? O0 : (tbl[r].ea == A1) ? O1 : 12'h000;
      check_all($sformatf("vec%0d", r), tbl[r].eg, tbl[r].es, tbl[r].ee, tbl[r].eer,
                tbl[r].ed, tbl[r].ea, eo);
    end
    sys_rst = 1'b0;
    hm_if.hm_end = 1'b0;
    hm_if.hm_error = 1'b0;

    // reset while a read is outstanding, then normal service
    req_start = 2'b01;
    tick();
    check_all("rstwait grant", 2'b01, 1, '0, '0, D5, A0, O0);
    tick();
    sys_rst = 1'b1;
    hm_if.hm_end = 1'b1;
    hm_if.hm_data = D1;
    tick();
    check_all("rstwait reset", '0, 0, '0, '0, '0, '0, '0);
    sys_rst = 1'b0;
    hm_if.hm_end = 1'b0;
    tick();
    check_all("rstwait regrant", 2'b01, 1, '0, '0, '0, A0, O0);
    // address change while waiting must not reach the host-memory port
    req_page_addr[63:0] = 64'hFFFF_0000_1234_5678;
    req_page_offset[11:0] = 12'hABC;
    tick();
    check_all("addr hold", 2'b01, 1, '0, '0, '0, A0, O0);
    set_fixed_addr();
    // requester withdraws during WAIT: completion still reported
    req_start = 2'b00;
    tick();
    check_all("drop wait", 2'b01, 1, '0, '0, '0, A0, O0);
    hm_if.hm_end = 1'b1;
    hm_if.hm_data = D2;
    tick();
    check_all("drop done", 2'b01, 0, 2'b01, '0, D2, A0, O0);
    hm_if.hm_end = 1'b0;
    tick();
    check_all("drop release", '0, 0, '0, '0, D2, A0, O0);

    // no hm_end: watchdog (if built) or indefinite wait
    req_start = 2'b10;
    tick();
    check_all("tmo entry", 2'b10, 1, '0, '0, D2, A1, O1);
`ifdef CHECKER_HM_ARB_TIMEOUT_EN
    for (int unsigned c = 1; c < TMO; c++) begin
      tick();
      check_all($sformatf("tmo wait%0d", c), 2'b10, 1, '0, '0, D2, A1, O1);
    end
    tick();
    check_all("tmo fire", 2'b10, 0, 2'b10, 2'b10, D2, A1, O1);
`else
    for (int unsigned c = 1; c < 20; c++) begin
      tick();
      check_all($sformatf("nowd wait%0d", c), 2'b10, 1, '0, '0, D2, A1, O1);
    end
    hm_if.hm_end = 1'b1;
    hm_if.hm_data = D3;
    tick();
    check_all("nowd done", 2'b10, 0, 2'b10, '0, D3, A1, O1);
    hm_if.hm_end = 1'b0;
`endif
    req_start = 2'b00;
    tick();
    check({"post idle grant"}, 64'(grant), 64'(0));

    // randomized traffic against the model
    sys_rst = 1'b1;
    req_start = '0;
    model_step();
    tick();
    check_all("rand reset", m_grant, m_start, m_end, m_err, m_data, m_addr, m_off);
    sys_rst = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      hold[i] = 0;
      idle[i] = $urandom_range(0, 3);
      done_seen[i] = 0;
    end
    for (int unsigned cyc = 0; cyc < 3000; cyc++) begin
      sys_rst        = ($urandom_range(0, 199) == 0);
      hm_if.hm_end   = ($urandom_range(0, 9) < 3);
      hm_if.hm_error = ($urandom_range(0, 3) == 0);
      hm_if.hm_data  = {$urandom, $urandom};
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_start[i] && $urandom_range(0, 7) == 0) begin
          req_page_addr[64*i +: 64]   = {$urandom, $urandom};
          req_page_offset[12*i +: 12] = 12'($urandom);
        end
      end
      model_step();
      tick();
      check_all("rand", m_grant, m_start, m_end, m_err, m_data, m_addr, m_off);
      // requesters: hold until req_end, linger 0..3 cycles, idle, request again
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_start[i]) begin
          if (req_end[i]) begin
            done_seen[i] = 1;
            hold[i] = $urandom_range(0, 3);
          end
          if (done_seen[i]) begin
            if (hold[i] == 0) begin
              req_start[i] = 1'b0;
              done_seen[i] = 0;
              idle[i] = $urandom_range(0, 4);
            end else begin
              hold[i]--;
            end
          end
        end else if (idle[i] == 0) begin
          req_start[i] = 1'b1;
          req_page_addr[64*i +: 64]   = {$urandom, $urandom};
          req_page_offset[12*i +: 12] = 12'($urandom);
        end else begin
          idle[i]--;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
